// File: rtl/autocorr_lag_seq.sv
`default_nettype none
// ============================================================================
// Module      : autocorr_lag_seq
// Description : Lag sequencer for the LPC autocorrelation datapath. Streams the
//               stored frame once per lag k = 0..K through the tapped shift
//               line and strobes the R[k] MAC clear/enable.
// Revision    : 1.0 - initial release
// ============================================================================
module autocorr_lag_seq #(
  parameter int FRAME_LEN = 160,
  parameter int NUM_LAGS  = 11,
  parameter int ADDR_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          order,
  input  logic                abort,
  output logic [NUM_LAGS-1:0] tap,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                acc_clr,
  output logic                acc_en,
  output logic                lag_valid,
  output logic [3:0]          lag_idx,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_COMMIT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [3:0]          c_k_max     = 4'(NUM_LAGS - 1);
  localparam logic [ADDR_W-1:0]   c_addr_last = ADDR_W'(FRAME_LEN - 1);
  localparam logic [NUM_LAGS-1:0] c_tap_one   = NUM_LAGS'(1);

  state_t              r_state, w_state;
  logic [3:0]          r_kmax, w_kmax;
  logic [3:0]          r_k, w_k;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [NUM_LAGS-1:0] r_tap, w_tap;
  logic                r_rd_en, w_rd_en;
  logic                r_acc_clr, w_acc_clr;
  logic                r_acc_en, w_acc_en;
  logic                r_lag_valid, w_lag_valid;
  logic                r_busy, w_busy;
  logic                r_done, w_done;

  always_comb begin
    w_state     = r_state;
    w_kmax      = r_kmax;
    w_k         = r_k;
    w_addr      = '0;
    w_tap       = '0;
    w_rd_en     = 1'b0;
    w_acc_clr   = 1'b0;
    w_lag_valid = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    // Samples with index below k would pair with stale line contents from the previous lag.
    w_acc_en    = r_rd_en && (r_addr >= {{(ADDR_W-4){1'b0}}, r_k});

    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state   = S_CLEAR;
          w_kmax    = (order > c_k_max) ? c_k_max : order;
          w_k       = 4'd0;
          w_tap     = c_tap_one;
          w_acc_clr = 1'b1;
          w_busy    = 1'b1;
        end
      end
      S_CLEAR: begin
        w_state = S_STREAM;
        w_rd_en = 1'b1;
        w_tap   = r_tap;
        w_busy  = 1'b1;
      end
      S_STREAM: begin
        w_tap  = r_tap;
        w_busy = 1'b1;
        if (r_addr == c_addr_last) begin
          w_state = S_DRAIN;
        end else begin
          w_rd_en = 1'b1;
          w_addr  = r_addr + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        // Tap is held so the final read, arriving a cycle late, still pairs correctly.
        w_state     = S_COMMIT;
        w_lag_valid = 1'b1;
        w_tap       = r_tap;
        w_busy      = 1'b1;
      end
      S_COMMIT: begin
        w_busy = 1'b1;
        if (r_k == r_kmax) begin
          w_state = S_DONE;
          w_done  = 1'b1;
        end else begin
          w_state   = S_CLEAR;
          w_k       = r_k + 4'd1;
          w_tap     = c_tap_one << w_k;
          w_acc_clr = 1'b1;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_k     = 4'd0;
      end
      default: begin
        w_state = S_IDLE;
        w_k     = 4'd0;
      end
    endcase

    if (abort && (r_state != S_IDLE)) begin
      w_state     = S_IDLE;
      w_k         = 4'd0;
      w_addr      = '0;
      w_tap       = '0;
      w_rd_en     = 1'b0;
      w_acc_clr   = 1'b0;
      w_acc_en    = 1'b0;
      w_lag_valid = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_kmax      <= 4'd0;
      r_k         <= 4'd0;
      r_addr      <= '0;
      r_tap       <= '0;
      r_rd_en     <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_acc_en    <= 1'b0;
      r_lag_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_kmax      <= w_kmax;
      r_k         <= w_k;
      r_addr      <= w_addr;
      r_tap       <= w_tap;
      r_rd_en     <= w_rd_en;
      r_acc_clr   <= w_acc_clr;
      r_acc_en    <= w_acc_en;
      r_lag_valid <= w_lag_valid;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  assign tap       = r_tap;
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_addr;
  assign acc_clr   = r_acc_clr;
  assign acc_en    = r_acc_en;
  assign lag_valid = r_lag_valid;
  assign lag_idx   = r_k;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire
